// File: rtl/sobel_seq_ctrl.sv
// Sobel sequencer: gathers a 3x3 pixel window, starts the Sobel core, and captures its result.
// Latency: start pulses 1 cycle after the 9th pixel; result_valid_o pulses 1 cycle after sobel_done_i.
// Backpressure: none. Pixels that arrive while busy are dropped and overrun_o is set. The core wait is bounded by TIMEOUT_CYC.
// Optional build macro SOBEL_SLIDING_WINDOW_EN keeps six pixels across starts. When it is undefined, each start needs nine fresh pixels.
module sobel_seq_ctrl #(
  parameter int MAX_PIXEL_BITS = 8,
  parameter int PX_W           = MAX_PIXEL_BITS,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic                clk_i,
  input  logic                nreset_i,
  input  logic                px_valid_i,
  input  logic [PX_W-1:0]     px_data_i,
  input  logic                abort_i,
  output logic [9*PX_W-1:0]   win_o,
  output logic                sobel_start_o,
  input  logic                sobel_done_i,
  input  logic [PX_W-1:0]     sobel_px_i,
  output logic [PX_W-1:0]     result_o,
  output logic                result_valid_o,
  output logic                overrun_o,
  output logic                timeout_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_START   = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  // The last wait cycle on which a missing done causes a timeout.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [7:0]              tmo_q, tmo_d;
  logic [8:0][PX_W-1:0]    win_q, win_d;
  logic [PX_W-1:0]         result_q, result_d;
  logic                    start_q, start_d;
  logic                    result_valid_q, result_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;

  // Next-state logic. Abort overrides every other event. The window is written only in S_IDLE and S_COLLECT.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tmo_d          = tmo_q;
    win_d          = win_q;
    result_d       = result_q;
    start_d        = 1'b0;
    result_valid_d = 1'b0;
    overrun_d      = overrun_q;
    timeout_d      = timeout_q;

    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (px_valid_i) begin
            win_d[0] = px_data_i;
            cnt_d    = 4'd1;
            state_d  = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (px_valid_i) begin
            win_d[cnt_q] = px_data_i;
            cnt_d        = cnt_q + 4'd1;
            if (cnt_q == 4'd8) begin
              state_d = S_START;
              start_d = 1'b1;
            end
          end
        end
        S_START: begin
          tmo_d   = 8'd0;
          state_d = S_WAIT;
          if (px_valid_i) begin
            overrun_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (px_valid_i) begin
            overrun_d = 1'b1;
          end
          // If done arrives on the final wait cycle, it takes priority over the timeout.
          if (sobel_done_i) begin
            result_d       = sobel_px_i;
            result_valid_d = 1'b1;
`ifdef SOBEL_SLIDING_WINDOW_EN
            // Shift out the oldest row. Three new pixels then complete the next window.
            for (int k = 0; k < 6; k++) begin
              win_d[k] = win_q[k+3];
            end
            cnt_d   = 4'd6;
            state_d = S_COLLECT;
`else
            cnt_d   = 4'd0;
            state_d = S_IDLE;
`endif
          end else if (tmo_q == TMO_LAST) begin
            timeout_d = 1'b1;
            cnt_d     = 4'd0;
            state_d   = S_IDLE;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      tmo_q          <= 8'd0;
      win_q          <= '0;
      result_q       <= '0;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      win_q          <= win_d;
      result_q       <= result_d;
      start_q        <= start_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

  assign win_o          = win_q;
  assign sobel_start_o  = start_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign overrun_o      = overrun_q;
  assign timeout_o      = timeout_q;
  assign busy_o         = (state_q == S_START) || (state_q == S_WAIT);

endmodule

// File: tb/tb_sobel_seq_ctrl.sv
// Directed bench for sobel_seq_ctrl: window fill, start/done handshake, timeout edge, abort, overrun, reset.
// Inputs change 1 time unit after the rising edge. Outputs are checked at that same point.
// Every comparison uses chk(). The final line reports the check and failure counts.
module tb_sobel_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        nreset_i;
  logic        px_valid_i;
  logic [7:0]  px_data_i;
  logic        abort_i;
  logic [71:0] win_o;
  logic        sobel_start_o;
  logic        sobel_done_i;
  logic [7:0]  sobel_px_i;
  logic [7:0]  result_o;
  logic        result_valid_o;
  logic        overrun_o;
  logic        timeout_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  sobel_seq_ctrl dut (
    .clk_i          (clk_i),
    .nreset_i       (nreset_i),
    .px_valid_i     (px_valid_i),
    .px_data_i      (px_data_i),
    .abort_i        (abort_i),
    .win_o          (win_o),
    .sobel_start_o  (sobel_start_o),
    .sobel_done_i   (sobel_done_i),
    .sobel_px_i     (sobel_px_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_px(input logic [7:0] v);
    px_valid_i = 1'b1;
    px_data_i  = v;
    tick();
    px_valid_i = 1'b0;
  endtask

  task automatic send_done(input logic [7:0] v);
    sobel_done_i = 1'b1;
    sobel_px_i   = v;
    tick();
    sobel_done_i = 1'b0;
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask

  // Builds the expected window for nine pixels base, base+1, ..., base+8, with slot 0 as the oldest.
  function automatic logic [71:0] ramp(input logic [7:0] base);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic fill9(input logic [7:0] base);
    for (int i = 0; i < 9; i++) send_px(base + 8'(i));
  endtask

  initial begin
    nreset_i     = 1'b0;
    px_valid_i   = 1'b0;
    px_data_i    = '0;
    abort_i      = 1'b0;
    sobel_done_i = 1'b0;
    sobel_px_i   = '0;
    tick();
    tick();
    chk("rst_win",     win_o, 72'd0);
    chk("rst_result",  72'(result_o), 72'd0);
    chk("rst_start",   72'(sobel_start_o), 72'd0);
    chk("rst_rvld",    72'(result_valid_o), 72'd0);
    chk("rst_overrun", 72'(overrun_o), 72'd0);
    chk("rst_timeout", 72'(timeout_o), 72'd0);
    chk("rst_busy",    72'(busy_o), 72'd0);
    nreset_i = 1'b1;
    tick();

    // Basic fill: pixels 1..9 arrive on consecutive cycles.
    for (int i = 1; i <= 8; i++) send_px(8'(i));
    chk("no_start_at_8", 72'(sobel_start_o), 72'd0);
    send_px(8'd9);
    chk("start_after_9", 72'(sobel_start_o), 72'd1);
    chk("busy_in_start", 72'(busy_o), 72'd1);
    chk("win_1_9",       win_o, ramp(8'd1));
    chk("win_slot0",     72'(win_o[7:0]), 72'd1);
    chk("win_slot8",     72'(win_o[71:64]), 72'd9);
    tick();
    chk("start_one_cycle", 72'(sobel_start_o), 72'd0);
    chk("busy_in_wait",    72'(busy_o), 72'd1);
    chk("win_stable_wait", win_o, ramp(8'd1));

    send_done(8'hA5);
    chk("result_a5",  72'(result_o), 72'hA5);
    chk("rvld_pulse", 72'(result_valid_o), 72'd1);
    chk("idle_after_done", 72'(busy_o), 72'd0);
    tick();
    chk("rvld_one_cycle", 72'(result_valid_o), 72'd0);

    // A done pulse outside S_WAIT must be ignored.
    send_done(8'h3C);
    chk("done_ignored_res",  72'(result_o), 72'hA5);
    chk("done_ignored_rvld", 72'(result_valid_o), 72'd0);

    fill9(8'd1);
    tick();
    send_done(8'h11);
`ifdef SOBEL_SLIDING_WINDOW_EN
    send_px(8'd10);
    send_px(8'd11);
    chk("slide_no_start_11", 72'(sobel_start_o), 72'd0);
    send_px(8'd12);
    chk("slide_start_12", 72'(sobel_start_o), 72'd1);
    chk("slide_win_4_12", win_o, ramp(8'd4));
`else
    for (int i = 10; i <= 17; i++) send_px(8'(i));
    chk("fresh_no_start_8", 72'(sobel_start_o), 72'd0);
    send_px(8'd18);
    chk("fresh_start_9", 72'(sobel_start_o), 72'd1);
    chk("fresh_win",     win_o, ramp(8'd10));
`endif
    tick();
    send_done(8'h22);
    chk("result_22", 72'(result_o), 72'h22);
    do_abort();

    // Abort and pixel in the same cycle during S_WAIT: abort wins, so there is no overrun.
    fill9(8'h20);
    tick();
    abort_i    = 1'b1;
    px_valid_i = 1'b1;
    px_data_i  = 8'hFF;
    tick();
    abort_i    = 1'b0;
    px_valid_i = 1'b0;
    chk("abort_px_no_ovr", 72'(overrun_o), 72'd0);
    chk("abort_not_busy",  72'(busy_o), 72'd0);
    chk("abort_keeps_win", win_o, ramp(8'h20));

    // Abort after 5 pixels: nine further pixels are needed for a start.
    for (int i = 0; i < 5; i++) send_px(8'h30 + 8'(i));
    do_abort();
    for (int i = 0; i < 8; i++) send_px(8'h40 + 8'(i));
    chk("abort_no_start_8", 72'(sobel_start_o), 72'd0);
    send_px(8'h48);
    chk("abort_start_9", 72'(sobel_start_o), 72'd1);
    chk("abort_win",     win_o, ramp(8'h40));
    tick();

    // A pixel arriving during S_WAIT is dropped and sets the sticky overrun flag.
    send_px(8'hFF);
    chk("overrun_set",    72'(overrun_o), 72'd1);
    chk("overrun_win",    win_o, ramp(8'h40));
    send_done(8'h5A);
    chk("result_5a",      72'(result_o), 72'h5A);
    chk("overrun_sticky", 72'(overrun_o), 72'd1);

    // Done on wait cycle 255 arrives just in time, so no timeout occurs.
    fill9(8'h50);
    tick();
    repeat (254) tick();
    chk("t254_no_timeout", 72'(timeout_o), 72'd0);
    chk("t254_busy",       72'(busy_o), 72'd1);
    send_done(8'h77);
    chk("done255_result",  72'(result_o), 72'h77);
    chk("done255_no_tmo",  72'(timeout_o), 72'd0);
    chk("done255_rvld",    72'(result_valid_o), 72'd1);

    // No done arrives: a timeout occurs at the end of wait cycle 255.
    fill9(8'h60);
    tick();
    repeat (254) tick();
    chk("tmo_not_yet", 72'(timeout_o), 72'd0);
    tick();
    chk("tmo_set",      72'(timeout_o), 72'd1);
    chk("tmo_not_busy", 72'(busy_o), 72'd0);
    chk("tmo_result",   72'(result_o), 72'h77);
    send_done(8'h99);
    chk("late_done_ignored", 72'(result_o), 72'h77);

    // Reset during S_WAIT: a later done must not update the result.
    fill9(8'h70);
    tick();
    nreset_i = 1'b0;
    tick();
    nreset_i = 1'b1;
    send_done(8'hEE);
    chk("rst_wait_result",  72'(result_o), 72'd0);
    chk("rst_wait_rvld",    72'(result_valid_o), 72'd0);
    chk("rst_wait_timeout", 72'(timeout_o), 72'd0);
    chk("rst_wait_overrun", 72'(overrun_o), 72'd0);
    chk("rst_wait_busy",    72'(busy_o), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_seq_ctrl.md
SOBEL_SEQ_CTRL -- requirements
Module: sobel_seq_ctrl

Interface
REQ-001 Parameter PX_W, default MAX_PIXEL_BITS (8): pixel width.
REQ-002 Parameter TIMEOUT_CYC, default 255: max cycles waited for sobel_done_i, range 1..255.
REQ-003 clk_i  input  1  single block clock; all state changes on its rising edge.
REQ-004 nreset_i  input  1  reset, synchronous, active-low.
REQ-005 px_valid_i  input  1  one-cycle pulse, new received pixel on px_data_i.
REQ-006 px_data_i  input  PX_W  received gray pixel.
REQ-007 abort_i  input  1  frame abort (chip-select released), synchronised to clk_i.
REQ-008 win_o  output  9*PX_W  3x3 window; slot k at bits [k*PX_W +: PX_W], slot 0 = oldest pixel.
REQ-009 sobel_start_o  output  1  one-cycle start pulse to the Sobel core.
REQ-010 sobel_done_i  input  1  one-cycle completion pulse from the Sobel core.
REQ-011 sobel_px_i  input  PX_W  Sobel result, valid with sobel_done_i.
REQ-012 result_o  output  PX_W  last Sobel result, fed to the SPI transmit path.
REQ-013 result_valid_o  output  1  one-cycle pulse when result_o updates.
REQ-014 overrun_o  output  1  sticky: pixel dropped while busy.
REQ-015 timeout_o  output  1  sticky: Sobel core failed to respond.
REQ-016 busy_o  output  1  high in S_START and S_WAIT.

Function
REQ-017 States S_IDLE, S_COLLECT, S_START, S_WAIT; encoding 2 bits.
REQ-018 S_IDLE: px_valid_i stores pixel in slot 0, count=1, goes to S_COLLECT.
REQ-019 S_COLLECT: each px_valid_i stores pixel in slot count, count increments; the pixel making count=9 moves to S_START.
REQ-020 S_START: sobel_start_o high exactly one cycle, i.e. the cycle after the 9th px_valid_i; timeout counter cleared; then S_WAIT.
REQ-021 win_o SHALL be stable from entry to S_START until leaving S_WAIT.
REQ-022 S_WAIT: sobel_done_i latches sobel_px_i into result_o on that edge, result_valid_o high the following cycle for one cycle, then S_IDLE (count=0).
REQ-023 S_WAIT: timeout counter increments each cycle without sobel_done_i; on reaching TIMEOUT_CYC set timeout_o, go S_IDLE, result_o unchanged.
REQ-024 sobel_done_i in the cycle the counter reaches TIMEOUT_CYC: done wins, no timeout.
REQ-025 sobel_done_i outside S_WAIT SHALL be ignored.
REQ-026 px_valid_i in S_START or S_WAIT: pixel dropped, overrun_o set.
REQ-027 abort_i in any state: next state S_IDLE, count=0, sobel_start_o low; result_o, win_o, sticky flags retained.
REQ-028 abort_i and px_valid_i same cycle: abort wins, pixel dropped, overrun_o not set.
REQ-029 overrun_o and timeout_o cleared only by reset.
REQ-030 Count width 4 bits; never exceeds 9.

Reset
REQ-031 nreset_i low at a rising edge: state S_IDLE, count 0, timeout counter 0, win_o 0, result_o 0, sobel_start_o 0, result_valid_o 0, overrun_o 0, timeout_o 0, busy_o 0.
REQ-032 Reset asserted mid-S_WAIT: a later sobel_done_i SHALL NOT update result_o.

Configuration
REQ-033 Macro SOBEL_SLIDING_WINDOW_EN defined: after sobel_done_i, window shifts left three slots (slots 3..8 to 0..5), count=6, next state S_COLLECT; three new pixels trigger the next start.
REQ-034 Macro undefined: after sobel_done_i, count=0, S_IDLE; nine fresh pixels required per start.
REQ-035 Timeout and abort SHALL always return to S_IDLE with count=0 in both builds.

Verification
REQ-036 Pixels 1..9 on consecutive cycles -> sobel_start_o pulses cycle after 9th, win_o slot0=1, slot8=9, busy_o=1.
REQ-037 After start, sobel_done_i with sobel_px_i=0xA5 -> result_o=0xA5, result_valid_o one pulse, state S_IDLE.
REQ-038 Start, no done for 255 cycles -> timeout_o=1, result_o unchanged, busy_o=0; done at cycle 255 instead -> no timeout.
REQ-039 px_valid_i during S_WAIT -> overrun_o=1, win_o unchanged; abort_i after 5 pixels -> 9 further pixels needed for start.
REQ-040 SOBEL_SLIDING_WINDOW_EN: pixels 1..9, done, pixels 10..12 -> second start, win_o = 4..12.
